// File: rtl/huffman_pkg.sv
// Shared constants and state encoding for the Huffman code-length generator.
// Holds default sizing, the FSM state type and the weight-width derivation.
package huffman_pkg;

  localparam int DEF_SYMBOLS    = 16;
  localparam int DEF_FREQ_WIDTH = 5;
  localparam int DEF_LEN_WIDTH  = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SELECT = 3'd2,
    MERGE  = 3'd3,
    FIXUP  = 3'd4,
    OUTPUT = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Sum of all frequencies: at most SYMBOLS*(2^FREQ_WIDTH-1),
  // so log2(SYMBOLS) extra bits are always enough.
  function automatic int weight_width(
    input int fw,
    input int syms
  );
    return fw + $clog2(syms);
  endfunction

endpackage

// File: rtl/huffman_min2_select.sv
// Combinational two-minimum finder over a packed weight vector.
// Ports: weights/active in; idx_a (min), idx_b (next min), valid out.
module huffman_min2_select #(
  parameter int N  = 16,
  parameter int W  = 9,
  parameter int IW = $clog2(N)
) (
  input  logic [N*W-1:0] weights,
  input  logic [N-1:0]   active,
  output logic [IW-1:0]  idx_a,
  output logic [IW-1:0]  idx_b,
  output logic           valid
);

  logic         found_a;
  logic         found_b;
  logic [W-1:0] wa;
  logic [W-1:0] wb;
  logic [W-1:0] wi;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    wa      = '0;
    wb      = '0;
    wi      = '0;
    idx_a   = '0;
    idx_b   = '0;
    for (int i = 0; i < N; i++) begin
      wi = weights[i*W +: W];
      if (active[i] && (!found_a || wi < wa)) begin
        found_a = 1'b1;
        wa      = wi;
        idx_a   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      wi = weights[i*W +: W];
      if (active[i] && IW'(i) != idx_a &&
          (!found_b || wi < wb)) begin
        found_b = 1'b1;
        wb      = wi;
        idx_b   = IW'(i);
      end
    end
    valid = found_a && found_b;
  end

endmodule

// File: rtl/huffman_code_length_gen.sv
// Streams in symbol frequencies, runs Huffman merges, streams out lengths.
// Ports: start/in_* load, out_* length stream, busy/done/len_overflow status.
module huffman_code_length_gen
  import huffman_pkg::*;
#(
  parameter int SYMBOLS      = DEF_SYMBOLS,
  parameter int FREQ_WIDTH   = DEF_FREQ_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int SYM_WIDTH    = $clog2(SYMBOLS),
  parameter int WEIGHT_WIDTH = weight_width(FREQ_WIDTH, SYMBOLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FREQ_WIDTH-1:0] in_freq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYM_WIDTH-1:0]  out_sym,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  len_overflow
);

  localparam int CW = $clog2(SYMBOLS + 1);
  localparam logic [SYM_WIDTH-1:0] LAST =
    SYM_WIDTH'(SYMBOLS - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  state_t state;

  logic [WEIGHT_WIDTH-1:0] weight [SYMBOLS];
  logic [SYMBOLS-1:0]      active;
  logic [SYMBOLS-1:0]      used;
  logic [SYM_WIDTH-1:0]    set    [SYMBOLS];
  logic [LEN_WIDTH-1:0]    len    [SYMBOLS];

  logic [SYM_WIDTH-1:0]    cnt;
  logic [CW-1:0]           act_cnt;
  logic [SYM_WIDTH-1:0]    sel_a;
  logic [SYM_WIDTH-1:0]    sel_b;
  logic [WEIGHT_WIDTH-1:0] sum;

  logic [SYMBOLS*WEIGHT_WIDTH-1:0] weights_flat;
  logic [SYM_WIDTH-1:0]            pick_a;
  logic [SYM_WIDTH-1:0]            pick_b;
  logic                            pick_valid;

  logic                 nz;
  logic [CW-1:0]        act_next;
  logic [SYM_WIDTH-1:0] lo;
  logic [SYM_WIDTH-1:0] hi;
  logic [SYM_WIDTH-1:0] set_a;
  logic [SYM_WIDTH-1:0] set_b;

  always_comb begin
    weights_flat = '0;
    for (int j = 0; j < SYMBOLS; j++)
      weights_flat[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = weight[j];
  end

  huffman_min2_select #(
    .N  (SYMBOLS),
    .W  (WEIGHT_WIDTH),
    .IW (SYM_WIDTH)
  ) u_min2 (
    .weights (weights_flat),
    .active  (active),
    .idx_a   (pick_a),
    .idx_b   (pick_b),
    .valid   (pick_valid)
  );

  assign nz       = (in_freq != '0);
  assign act_next = act_cnt + CW'(nz);
  assign lo       = (sel_a < sel_b) ? sel_a : sel_b;
  assign hi       = (sel_a < sel_b) ? sel_b : sel_a;
  assign set_a    = set[sel_a];
  assign set_b    = set[sel_b];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      act_cnt      <= '0;
      sel_a        <= '0;
      sel_b        <= '0;
      sum          <= '0;
      len_overflow <= 1'b0;
      active       <= '0;
      used         <= '0;
      for (int j = 0; j < SYMBOLS; j++) begin
        weight[j] <= '0;
        set[j]    <= '0;
        len[j]    <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            cnt          <= '0;
            act_cnt      <= '0;
            len_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            weight[cnt] <= WEIGHT_WIDTH'(in_freq);
            active[cnt] <= nz;
            used[cnt]   <= nz;
            set[cnt]    <= cnt;
            len[cnt]    <= '0;
            act_cnt     <= act_next;
            cnt         <= cnt + 1'b1;
            if (cnt == LAST) begin
              cnt <= '0;
              if (act_next == '0)
                state <= OUTPUT;
              else if (act_next == CW'(1))
                state <= FIXUP;
              else
                state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (pick_valid) begin
            sel_a <= pick_a;
            sel_b <= pick_b;
            sum   <= weight[pick_a] + weight[pick_b];
            state <= MERGE;
          end else begin
            state <= OUTPUT;
          end
        end
        MERGE: begin
          // Every leaf under either subtree gets one level deeper.
          for (int j = 0; j < SYMBOLS; j++) begin
            if (used[j] && (set[j] == set_a ||
                            set[j] == set_b)) begin
              if (len[j] == LEN_MAX)
                len_overflow <= 1'b1;
              else
                len[j] <= len[j] + 1'b1;
            end
            if (set[j] == set_b)
              set[j] <= set_a;
          end
          weight[lo] <= sum;
          active[hi] <= 1'b0;
          act_cnt    <= act_cnt - 1'b1;
          if (act_cnt == CW'(2))
            state <= OUTPUT;
          else
            state <= SELECT;
        end
        FIXUP: begin
          for (int j = 0; j < SYMBOLS; j++)
            if (active[j])
              len[j] <= LEN_WIDTH'(1);
          state <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign done      = (state == DONE);
  assign out_sym   = out_valid ? cnt : '0;
  assign out_len   = out_valid ? len[cnt] : '0;
  assign out_last  = out_valid && (cnt == LAST);

endmodule

// File: tb/tb_huffman_code_length_gen.sv
// Self-checking bench for huffman_code_length_gen.
// Two instances: 16 symbols/5-bit lengths and 8 symbols/2-bit lengths.
module tb_huffman_code_length_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start16 = 1'b0;
  logic       start8 = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_freq = '0;

  logic       in_ready16, out_valid16, out_last16;
  logic       busy16, done16, ovf16;
  logic [3:0] out_sym16;
  logic [4:0] out_len16;

  logic       in_ready8, out_valid8, out_last8;
  logic       busy8, done8, ovf8;
  logic [2:0] out_sym8;
  logic [1:0] out_len8;

  always #5 clk = ~clk;

  huffman_code_length_gen u16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .in_valid     (in_valid),
    .in_ready     (in_ready16),
    .in_freq      (in_freq),
    .out_valid    (out_valid16),
    .out_ready    (out_ready),
    .out_sym      (out_sym16),
    .out_len      (out_len16),
    .out_last     (out_last16),
    .busy         (busy16),
    .done         (done16),
    .len_overflow (ovf16)
  );

  huffman_code_length_gen #(
    .SYMBOLS   (8),
    .LEN_WIDTH (2)
  ) u8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start8),
    .in_valid     (in_valid),
    .in_ready     (in_ready8),
    .in_freq      (in_freq),
    .out_valid    (out_valid8),
    .out_ready    (out_ready),
    .out_sym      (out_sym8),
    .out_len      (out_len8),
    .out_last     (out_last8),
    .busy         (busy8),
    .done         (done8),
    .len_overflow (ovf8)
  );

  bit   sel = 1'b0;
  logic m_in_ready, m_out_valid, m_out_last;
  logic m_busy, m_done, m_ovf;
  int   m_sym, m_len;

  always_comb begin
    m_in_ready  = sel ? in_ready8  : in_ready16;
    m_out_valid = sel ? out_valid8 : out_valid16;
    m_out_last  = sel ? out_last8  : out_last16;
    m_busy      = sel ? busy8      : busy16;
    m_done      = sel ? done8      : done16;
    m_ovf       = sel ? ovf8       : ovf16;
    m_sym       = sel ? int'(out_sym8) : int'(out_sym16);
    m_len       = sel ? int'(out_len8) : int'(out_len16);
  end

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;

  always @(posedge clk)
    if (done16 || done8) done_seen++;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Huffman by repeated two-minimum merges over leaf sets.
  task automatic model(input int n, input int lw,
                       input int f[16],
                       output int len[16],
                       output bit ovf, output int lat);
    int        w[16];
    bit        act[16];
    bit [15:0] mem[16];
    bit [15:0] one;
    int        nact, lmax, a, b, lo, hi;
    one  = 16'd1;
    nact = 0;
    lmax = (1 << lw) - 1;
    ovf  = 1'b0;
    lat  = 0;
    for (int i = 0; i < 16; i++) begin
      len[i] = 0;
      w[i]   = f[i];
      act[i] = (i < n) && (f[i] != 0);
      mem[i] = one << i;
      if (act[i]) nact++;
    end
    if (nact == 1) begin
      lat = 1;
      for (int i = 0; i < 16; i++)
        if (act[i]) len[i] = 1;
    end
    while (nact > 1) begin
      a = -1;
      for (int i = 0; i < 16; i++)
        if (act[i] && (a < 0 || w[i] < w[a])) a = i;
      b = -1;
      for (int i = 0; i < 16; i++)
        if (act[i] && i != a && (b < 0 || w[i] < w[b]))
          b = i;
      for (int j = 0; j < 16; j++)
        if (mem[a][j] || mem[b][j]) begin
          if (len[j] == lmax) ovf = 1'b1;
          else len[j]++;
        end
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      mem[lo] = mem[a] | mem[b];
      w[lo]   = w[a] + w[b];
      act[hi] = 1'b0;
      nact--;
      lat += 2;
    end
  endtask

  task automatic do_load(input bit s, input int f[16],
                         input string tag);
    int n;
    n = s ? 8 : 16;
    sel = s;
    @(negedge clk);
    if (s) start8 = 1'b1;
    else   start16 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    chk({tag, "_in_ready"}, int'(m_in_ready), 1);
    chk({tag, "_ovf_clr"}, int'(m_ovf), 0);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_freq  = 5'(f[k]);
      // A start during LOAD must be ignored.
      if (k == 2) begin
        if (s) start8 = 1'b1;
        else   start16 = 1'b1;
      end
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input bit s, input int f[16],
                         input bit bp, input string tag);
    int n, lw, lat, cyc, idx, d0;
    int exp_len[16];
    bit exp_ovf;
    n  = s ? 8 : 16;
    lw = s ? 2 : 5;
    model(n, lw, f, exp_len, exp_ovf, lat);
    do_load(s, f, tag);
    cyc = 0;
    while (!m_out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, lat);
    d0  = done_seen;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      out_ready = bp ? (cyc % 2 == 0) : 1'b1;
      chk({tag, "_out_valid"}, int'(m_out_valid), 1);
      chk({tag, "_out_sym"}, m_sym, idx);
      chk({tag, "_out_len"}, m_len, exp_len[idx]);
      chk({tag, "_out_last"}, int'(m_out_last),
          int'(idx == n - 1));
      if (out_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_beats"}, idx, n);
    chk({tag, "_done"}, int'(m_done), 1);
    chk({tag, "_valid_off"}, int'(m_out_valid), 0);
    @(negedge clk);
    chk({tag, "_done_once"}, done_seen - d0, 1);
    chk({tag, "_idle"}, int'(m_busy), 0);
    chk({tag, "_ovf"}, int'(m_ovf), int'(exp_ovf));
  endtask

  int f[16];

  task automatic clear_f();
    for (int i = 0; i < 16; i++) f[i] = 0;
  endtask

  initial begin
    int d0;
    #1;
    chk("rst_busy", int'(busy16), 0);
    chk("rst_in_ready", int'(in_ready16), 0);
    chk("rst_out_valid", int'(out_valid16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_ovf", int'(ovf16), 0);
    chk("rst_sym_len", m_sym + m_len, 0);
    chk("rst_busy8", int'(busy8), 0);
    @(negedge clk);
    reset = 1'b0;

    clear_f();
    f[0] = 1; f[1] = 1; f[2] = 2; f[3] = 4;
    run_job(1'b0, f, 1'b0, "j1124");

    clear_f();
    run_job(1'b0, f, 1'b0, "zero");

    clear_f();
    f[2] = 7;
    run_job(1'b0, f, 1'b0, "single");

    for (int i = 0; i < 16; i++) f[i] = 1;
    run_job(1'b0, f, 1'b0, "ones");

    clear_f();
    f[0] = 1; f[1] = 1; f[2] = 2;  f[3] = 3;
    f[4] = 5; f[5] = 8; f[6] = 13; f[7] = 21;
    run_job(1'b1, f, 1'b0, "fib");
    repeat (4) @(negedge clk);
    chk("fib_ovf_sticky", int'(ovf8), 1);

    clear_f();
    f[0] = 1; f[1] = 1; f[2] = 2; f[3] = 4;
    run_job(1'b0, f, 1'b1, "bp1124");

    clear_f();
    f[0] = 1; f[1] = 1; f[2] = 2; f[3] = 4;
    do_load(1'b0, f, "rst");
    @(negedge clk);
    chk("rst_mid_busy", int'(busy16), 1);
    reset = 1'b1;
    #1;
    chk("rstm_busy", int'(busy16), 0);
    chk("rstm_out_valid", int'(out_valid16), 0);
    chk("rstm_in_ready", int'(in_ready16), 0);
    chk("rstm_done", int'(done16), 0);
    chk("rstm_sym_len", m_sym + m_len, 0);
    d0 = done_seen;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstm_no_done", done_seen - d0, 0);
    chk("rstm_idle", int'(busy16), 0);
    run_job(1'b0, f, 1'b0, "rerun");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++)
        f[i] = ($urandom_range(0, 9) < 3) ?
               0 : int'($urandom_range(1, 31));
      run_job(t[0], f, t[1], "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/huffman_code_length_gen.md
Name: huffman_code_length_gen

Overview:
- Parametrised successor to the fixed 16-symbol code-size generator.
- Symbol frequencies are streamed in at run time, with no hard-coded tables.
- Performs a true Huffman merge (two minimum weights per step) and reports the code length of every symbol.
- Code lengths are streamed out in symbol-index order to the downstream canonical-code assigner.

Parameters:
- SYMBOLS, 16, number of symbols and tree leaves (≥2).
- FREQ_WIDTH, 5, width of the input frequency.
- LEN_WIDTH, 5, width of the output code length.
- SYM_WIDTH, $clog2(SYMBOLS), width of the symbol index.
- WEIGHT_WIDTH, FREQ_WIDTH+$clog2(SYMBOLS), internal weight width; sums never overflow.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new job, honoured only in IDLE.
- in_valid  in  1  frequency beat valid.
- in_ready  out  1  high only in LOAD.
- in_freq  in  FREQ_WIDTH  frequency of the next symbol; beats arrive for symbol 0,1,…,SYMBOLS-1 in order.
- out_valid  out  1  code-length beat valid.
- out_ready  in  1  downstream accept.
- out_sym  out  SYM_WIDTH  symbol index of the current beat.
- out_len  out  LEN_WIDTH  code length; 0 means the symbol is unused.
- out_last  out  1  high on the beat for symbol SYMBOLS-1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last output beat is accepted.
- len_overflow  out  1  sticky; cleared on an accepted start.

Behaviour:
- Reset (asynchronous) forces the state to IDLE and drives every output to 0. All node, length and counter storage clears.
- Reset mid-job aborts the job; no done pulse is produced.
- Storage per node i (0..SYMBOLS-1): weight[i], active[i], set[i] (leaf group id), len[i].
- Load:
  - The counter starts at 0 and the active counter at 0.
  - Beats transfer on in_valid&&in_ready, one per cycle maximum.
  - On each beat: weight[k]=in_freq, active[k]=(in_freq!=0), set[k]=k, len[k]=0. The active count increments if in_freq!=0.
  - After beat SYMBOLS-1 the next state is chosen by the final active count:
    - 0 → OUTPUT (all lengths 0).
    - 1 → FIXUP.
    - ≥2 → SELECT.
  - The counter-based check uses the count including the final beat.
- States: IDLE → LOAD → {SELECT ⇄ MERGE | FIXUP} → OUTPUT → DONE → IDLE.
- FIXUP (1 cycle): the single active symbol gets len=1.
- SELECT (1 cycle, combinational scan):
  - Finds among active nodes the minimum weight a and the next minimum b (a≠b).
  - Ties go to the lowest node index, for a first and then for b.
  - Latches a, b, and weight[a]+weight[b].
- MERGE (1 cycle):
  - For every leaf j with active frequency whose set[j]==set[a] or set[j]==set[b]: len[j]+=1.
  - If the result would exceed 2^LEN_WIDTH-1, len[j] saturates and len_overflow sets.
  - Leaves in set[b] are relabelled to set[a].
  - weight[min(a,b)]=sum and active[max(a,b)]=0; the surviving node index is min(a,b).
  - The active count decrements. If the new count is 1 → OUTPUT, else → SELECT.
- Merge latency: exactly 2 cycles per merge; a job with N≥2 non-zero symbols spends 2·(N−1) cycles between load end and OUTPUT.
- OUTPUT:
  - The index counter runs 0..SYMBOLS-1.
  - out_valid=1 with out_sym=index and out_len=len[index].
  - Fields hold stable while out_ready=0.
  - The index advances on out_valid&&out_ready.
  - The beat for index SYMBOLS-1 carries out_last=1. Its acceptance → DONE.
- DONE: done=1 for 1 cycle, then → IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored, and no beat is consumed.

Decomposition:
- Shared package huffman_pkg holds:
  - the state encoding (localparam enum: IDLE, LOAD, SELECT, MERGE, FIXUP, OUTPUT, DONE);
  - the default SYMBOLS/FREQ_WIDTH/LEN_WIDTH constants;
  - the WEIGHT_WIDTH derivation.
- One natural sub-module, huffman_min2_select: purely combinational.
  - Inputs: packed weights and active mask.
  - Outputs: idx_a, idx_b, valid, with lowest-index tie-break.
  - It is reused by the later length-limiting block.

Test Plan:
- SYMBOLS=4, freqs {1,1,2,4}:
  - Merges are (0,1), then (0,2), then (0,3), taking 6 cycles from the end of load to the first out_valid−1.
  - Output lengths {3,3,2,1}, out_last on sym 3, done pulse once, len_overflow=0.
- SYMBOLS=16, freqs all zero → OUTPUT directly after load; 16 beats with out_len=0; done pulses.
- SYMBOLS=16, only symbol 2 freq=7 → symbol 2 len=1, all others 0.
- SYMBOLS=16, all freqs 1 → every out_len=4; 30 merge cycles.
- SYMBOLS=8, LEN_WIDTH=2, freqs {1,1,2,3,5,8,13,21}:
  - Lengths saturate at 3 for symbols 0–4; symbol 5 len=3, symbol 6 len=2, symbol 7 len=1.
  - len_overflow=1 and stays set until the next start.
- Backpressure and reset:
  - With out_ready toggled 1/0 every cycle, out_sym and out_len hold while out_ready is low; the sequence is unchanged.
  - Reset asserted during MERGE: all outputs 0, state IDLE, no done pulse. A re-run of the {1,1,2,4} job then gives {3,3,2,1}.
